tap_controller: RTL and testbench

//  IEEE 1149.1 TAP controller. A 16-state FSM clocked by TCK and steered by TMS.

---
 rtl/jtag_pkg.sv | 37 +++
 rtl/tap_fsm.sv | 65 ++++++
 rtl/tap_controller.sv | 53 +++++
 tb/tb_tap_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state width, IEEE 1149.1 state encoding and
// the decoded-control payload passed from the FSM to the output registers.
package jtag_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] TLR   = 4'hF;
    localparam logic [STATE_W-1:0] RTI   = 4'hC;
    localparam logic [STATE_W-1:0] SELDR = 4'h7;
    localparam logic [STATE_W-1:0] CAPDR = 4'h6;
    localparam logic [STATE_W-1:0] SHDR  = 4'h2;
    localparam logic [STATE_W-1:0] EX1DR = 4'h1;
    localparam logic [STATE_W-1:0] PAUDR = 4'h3;
    localparam logic [STATE_W-1:0] EX2DR = 4'h0;
    localparam logic [STATE_W-1:0] UPDDR = 4'h5;
    localparam logic [STATE_W-1:0] SELIR = 4'h4;
    localparam logic [STATE_W-1:0] CAPIR = 4'hE;
    localparam logic [STATE_W-1:0] SHIR  = 4'hA;
    localparam logic [STATE_W-1:0] EX1IR = 4'h9;
    localparam logic [STATE_W-1:0] PAUIR = 4'hB;
    localparam logic [STATE_W-1:0] EX2IR = 4'h8;
    localparam logic [STATE_W-1:0] UPDIR = 4'hD;

    // Controls decoded from the current state; all-zero is the reset value.
    typedef struct packed {
        logic sh_ir_en;
        logic sh_dr_en;
        logic shift_ir;
        logic shift_dr;
        logic upd_ir;
        logic upd_dr;
        logic sel;
        logic ena;
        logic rst_n;
    } tap_dec_t;

endpackage

// File: rtl/tap_fsm.sv
// TAP state machine: posedge-TCK state register, 1149.1 next-state logic and
// a combinational decode of the current state into control flags.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic               tck_i,
    input  logic               trst_i,
    input  logic               tms_i,
    output logic [STATE_W-1:0] state_o,
    output tap_dec_t           dec_c_o
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    // State register; TRST forces Test-Logic-Reset immediately.
    always_ff @(posedge tck_i or posedge trst_i) begin
        if (trst_i) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Standard 1149.1 transitions steered by TMS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:   state_d = tms_i ? TLR   : RTI;
            RTI:   state_d = tms_i ? SELDR : RTI;
            SELDR: state_d = tms_i ? SELIR : CAPDR;
            CAPDR: state_d = tms_i ? EX1DR : SHDR;
            SHDR:  state_d = tms_i ? EX1DR : SHDR;
            EX1DR: state_d = tms_i ? UPDDR : PAUDR;
            PAUDR: state_d = tms_i ? EX2DR : PAUDR;
            EX2DR: state_d = tms_i ? UPDDR : SHDR;
            UPDDR: state_d = tms_i ? SELDR : RTI;
            SELIR: state_d = tms_i ? TLR   : CAPIR;
            CAPIR: state_d = tms_i ? EX1IR : SHIR;
            SHIR:  state_d = tms_i ? EX1IR : SHIR;
            EX1IR: state_d = tms_i ? UPDIR : PAUIR;
            PAUIR: state_d = tms_i ? EX2IR : PAUIR;
            EX2IR: state_d = tms_i ? UPDIR : SHIR;
            UPDIR: state_d = tms_i ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Decode the current state into the shift/update/select controls.
    always_comb begin
        dec_c_o          = '0;
        dec_c_o.sh_ir_en = (state_q == CAPIR) || (state_q == SHIR);
        dec_c_o.sh_dr_en = (state_q == CAPDR) || (state_q == SHDR);
        dec_c_o.shift_ir = (state_q == SHIR);
        dec_c_o.shift_dr = (state_q == SHDR);
        dec_c_o.upd_ir   = (state_q == UPDIR);
        dec_c_o.upd_dr   = (state_q == UPDDR);
        dec_c_o.sel      = state_q inside {SELIR, CAPIR, SHIR, EX1IR, PAUIR, EX2IR, UPDIR};
        dec_c_o.ena      = (state_q == SHIR) || (state_q == SHDR);
        dec_c_o.rst_n    = (state_q != TLR);
    end

    assign state_o = state_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller top: FSM plus negedge-registered IR/DR controls
// and glitch-free gated shift clocks for the boundary cells.
module tap_controller
    import jtag_pkg::*;
(
    input  logic               TCK,
    input  logic               TRST,
    input  logic               TMS,
    output logic               ShiftIR,
    output logic               ClockIR,
    output logic               UpdateIR,
    output logic               ShiftDR,
    output logic               ClockDR,
    output logic               UpdateDR,
    output logic               Select,
    output logic               Enable,
    output logic               ResetN,
    output logic [STATE_W-1:0] State
);

    tap_dec_t ctl_d;
    tap_dec_t ctl_q;

    tap_fsm u_fsm (
        .tck_i   (TCK),
        .trst_i  (TRST),
        .tms_i   (TMS),
        .state_o (State),
        .dec_c_o (ctl_d)
    );

    // Controls change only while TCK is low, so the clock gates below never glitch.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            ctl_q <= '0;
        end else begin
            ctl_q <= ctl_d;
        end
    end

    assign ShiftIR  = ctl_q.shift_ir;
    assign ShiftDR  = ctl_q.shift_dr;
    assign UpdateIR = ctl_q.upd_ir;
    assign UpdateDR = ctl_q.upd_dr;
    assign Select   = ctl_q.sel;
    assign Enable   = ctl_q.ena;
    assign ResetN   = ctl_q.rst_n;

    // Gated shift clocks: rising edge aligned with posedge TCK while enabled.
    assign ClockIR = TCK & ctl_q.sh_ir_en;
    assign ClockDR = TCK & ctl_q.sh_dr_en;

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: the driver pushes hand-computed
// expectations per TCK step, the monitor pops and compares each negedge.
module tb_tap_controller;

    logic       tck;
    logic       trst;
    logic       tms;
    logic       shift_ir, clock_ir, update_ir;
    logic       shift_dr, clock_dr, update_dr;
    logic       sel, ena, rst_n;
    logic [3:0] state;

    tap_controller dut (
        .TCK      (tck),
        .TRST     (trst),
        .TMS      (tms),
        .ShiftIR  (shift_ir),
        .ClockIR  (clock_ir),
        .UpdateIR (update_ir),
        .ShiftDR  (shift_dr),
        .ClockDR  (clock_dr),
        .UpdateDR (update_dr),
        .Select   (sel),
        .Enable   (ena),
        .ResetN   (rst_n),
        .State    (state)
    );

    // flags = {ShiftIR, ShiftDR, UpdateIR, UpdateDR, Select, Enable, ResetN}
    typedef struct {
        int         id;
        logic [3:0] st;
        logic [6:0] fl;
        int         ird;
        int         drd;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;
    int   ir_cnt   = 0;
    int   dr_cnt   = 0;
    int   upd_cnt  = 0;

    initial begin
        tck = 1'b0;
        forever #5 tck = ~tck;
    end

    always @(posedge clock_ir) ir_cnt = ir_cnt + 1;
    always @(posedge clock_dr) dr_cnt = dr_cnt + 1;
    always @(posedge update_ir or posedge update_dr) upd_cnt = upd_cnt + 1;

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, id, act, exp);
        end
    endtask

    // One TCK cycle: drive TMS while TCK is low, queue the expected result.
    task automatic step(input logic t, input logic [3:0] st, input logic [6:0] fl,
                        input int ird, input int drd);
        exp_t e;
        @(negedge tck);
        #1 tms = t;
        @(posedge tck);
        #1;
        step_id = step_id + 1;
        e.id  = step_id;
        e.st  = st;
        e.fl  = fl;
        e.ird = ird;
        e.drd = drd;
        q.push_back(e);
    endtask

    // Monitor: samples after each negedge, once the output registers settle.
    initial begin : monitor
        exp_t e;
        int   ir_last = 0;
        int   dr_last = 0;
        int   ird, drd;
        forever begin
            @(negedge tck);
            #2;
            ird     = ir_cnt - ir_last;
            drd     = dr_cnt - dr_last;
            ir_last = ir_cnt;
            dr_last = dr_cnt;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", e.id, int'(state), int'(e.st));
                chk("flags", e.id,
                    int'({shift_ir, shift_dr, update_ir, update_dr, sel, ena, rst_n}),
                    int'(e.fl));
                chk("clockir_edges", e.id, ird, e.ird);
                chk("clockdr_edges", e.id, drd, e.drd);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int ir_before;
        int upd_before;
        trst = 1'b1;
        tms  = 1'b1;
        #2;
        chk("reset_state", 0, int'(state), 'hF);
        chk("reset_flags", 0,
            int'({shift_ir, shift_dr, update_ir, update_dr, sel, ena, rst_n}), 0);
        chk("reset_clocks", 0, int'({clock_ir, clock_dr}), 0);
        #11 trst = 1'b0;

        // TLR -> RTI -> SelDR -> SelIR -> CapIR
        step(1'b0, 4'hC, 7'b0000001, 0, 0);
        step(1'b1, 4'h7, 7'b0000001, 0, 0);
        step(1'b1, 4'h4, 7'b0000101, 0, 0);
        step(1'b0, 4'hE, 7'b0000101, 0, 0);
        // Three cycles in ShIR, then Ex1IR; one gated edge per posedge leaving CapIR/ShIR
        step(1'b0, 4'hA, 7'b1000111, 1, 0);
        step(1'b0, 4'hA, 7'b1000111, 1, 0);
        step(1'b0, 4'hA, 7'b1000111, 1, 0);
        step(1'b1, 4'h9, 7'b0000101, 1, 0);
        // UpdIR for one period, then SelDR
        step(1'b1, 4'hD, 7'b0010101, 0, 0);
        step(1'b1, 4'h7, 7'b0000001, 0, 0);
        // SelDR -> SelIR -> TLR -> RTI
        step(1'b1, 4'h4, 7'b0000101, 0, 0);
        step(1'b1, 4'hF, 7'b0000000, 0, 0);
        step(1'b0, 4'hC, 7'b0000001, 0, 0);
        // DR path through PauDR: TMS 1,0,0,0,1,0,1,1 then back to RTI
        step(1'b1, 4'h7, 7'b0000001, 0, 0);
        step(1'b0, 4'h6, 7'b0000001, 0, 0);
        step(1'b0, 4'h2, 7'b0100011, 0, 1);
        step(1'b0, 4'h2, 7'b0100011, 0, 1);
        step(1'b1, 4'h1, 7'b0000001, 0, 1);
        step(1'b0, 4'h3, 7'b0000001, 0, 0);
        step(1'b1, 4'h0, 7'b0000001, 0, 0);
        step(1'b1, 4'h5, 7'b0001001, 0, 0);
        step(1'b0, 4'hC, 7'b0000001, 0, 0);
        // Into ShDR, then five TMS=1 cycles reach TLR
        step(1'b1, 4'h7, 7'b0000001, 0, 0);
        step(1'b0, 4'h6, 7'b0000001, 0, 0);
        step(1'b0, 4'h2, 7'b0100011, 0, 1);
        step(1'b1, 4'h1, 7'b0000001, 0, 1);
        step(1'b1, 4'h5, 7'b0001001, 0, 0);
        step(1'b1, 4'h7, 7'b0000001, 0, 0);
        step(1'b1, 4'h4, 7'b0000101, 0, 0);
        step(1'b1, 4'hF, 7'b0000000, 0, 0);
        // Back into ShIR for the asynchronous reset test
        step(1'b0, 4'hC, 7'b0000001, 0, 0);
        step(1'b1, 4'h7, 7'b0000001, 0, 0);
        step(1'b1, 4'h4, 7'b0000101, 0, 0);
        step(1'b0, 4'hE, 7'b0000101, 0, 0);
        step(1'b0, 4'hA, 7'b1000111, 1, 0);

        // Stay in ShIR, then assert TRST while the gated IR clock is high
        @(negedge tck);
        #1 tms = 1'b0;
        @(posedge tck);
        #2;
        chk("clockir_high_in_shir", 100, int'(clock_ir), 1);
        chk("state_shir_before_trst", 100, int'(state), 'hA);
        trst = 1'b1;
        #1;
        ir_before  = ir_cnt;
        upd_before = upd_cnt;
        chk("trst_state", 101, int'(state), 'hF);
        chk("trst_clockir", 101, int'(clock_ir), 0);
        chk("trst_flags", 101,
            int'({shift_ir, shift_dr, update_ir, update_dr, sel, ena, rst_n}), 0);
        @(negedge tck);
        #3;
        chk("trst_hold_state", 102, int'(state), 'hF);
        chk("trst_hold_flags", 102,
            int'({shift_ir, shift_dr, update_ir, update_dr, sel, ena, rst_n}), 0);
        tms  = 1'b1;
        trst = 1'b0;
        @(posedge tck);
        #2;
        chk("post_trst_state", 103, int'(state), 'hF);
        chk("post_trst_clockir", 103, int'(clock_ir), 0);
        chk("trst_no_clockir_edge", 103, ir_cnt - ir_before, 0);
        chk("trst_no_update", 103, upd_cnt - upd_before, 0);

        // Normal operation resumes from TLR
        step(1'b0, 4'hC, 7'b0000001, 0, 0);
        step(1'b1, 4'h7, 7'b0000001, 0, 0);

        repeat (3) @(negedge tck);
        #5;
        chk("scoreboard_drained", 200, q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
